// File: rtl/fifo_sched_pkg.sv
// Shared types and defaults for the FIFO read-side schedulers.
package fifo_sched_pkg;

  localparam int DEF_NUM_Q        = 4;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_WEIGHT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } sched_state_e;

  // Width of a queue index; never narrower than one bit.
  function automatic int qid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set request after base,
// wrapping around, with base itself checked last.
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = qid_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] pos;

  // Walk base+1 .. base+N; the wrap is an explicit compare so N need not be a power of two.
  always_comb begin
    found_o = 1'b0;
    idx_o   = base_i;
    pos     = '0;
    for (int k = 1; k <= N; k++) begin
      pos = {1'b0, base_i} + (IW+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (!found_o && req_i[pos[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wrr_scheduler.sv
// Weighted round-robin drain of NUM_Q registered-output FIFOs into one
// valid/ready stream tagged with the source queue ID.
//
// Handshake: a word transfers on any rising edge where out_valid && out_ready.
// Once out_valid is high, out_data/out_qid hold until that transfer; no new
// read is issued while the slot is occupied and not being accepted.
module fifo_wrr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter  int NUM_Q        = DEF_NUM_Q,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  localparam int QW           = qid_width(NUM_Q)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_Q*WEIGHT_WIDTH-1:0] weights,
  input  logic [NUM_Q-1:0]              q_empty,
  output logic [NUM_Q-1:0]              q_rd_en,
  input  logic [NUM_Q*DATA_WIDTH-1:0]   q_dataout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [QW-1:0]                 out_qid,
  output sched_state_e                  dbg_state_o
);

  localparam logic [WEIGHT_WIDTH-1:0] ONE_W = WEIGHT_WIDTH'(1);

  sched_state_e            state_q;
  logic [QW-1:0]           cur_q;
  logic [WEIGHT_WIDTH-1:0] credit_q;
  logic                    out_valid_q;
  logic [QW-1:0]           out_qid_q;

  logic [NUM_Q-1:0]        eligible;
  logic                    any_elig;
  logic [QW-1:0]           pick_idx;
  logic                    cont_turn;
  logic [QW-1:0]           target;
  logic [WEIGHT_WIDTH-1:0] tgt_weight;
  logic                    slot_free;
  logic                    issue;

  // A queue competes only when it has data and a nonzero weight.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      eligible[i] = !q_empty[i] && (weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end
  end

  rr_pick #(.N(NUM_Q), .IW(QW)) u_pick (
    .req_i   (eligible),
    .base_i  (cur_q),
    .found_o (any_elig),
    .idx_o   (pick_idx)
  );

  assign slot_free = !out_valid_q || out_ready;
  // rst_n gates the strobe so reads stop the instant reset asserts.
  assign issue     = rst_n && enable && slot_free && any_elig;
  assign cont_turn = (state_q == SERVE) && (credit_q != '0) && eligible[cur_q];
  assign target    = cont_turn ? cur_q : pick_idx;

  // Weight of the queue about to start a turn; only used at turn start.
  always_comb begin
    tgt_weight = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (QW'(i) == target) tgt_weight = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // One-hot read strobe towards the selected FIFO.
  always_comb begin
    q_rd_en = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (issue && (QW'(i) == target)) q_rd_en[i] = 1'b1;
    end
  end

  // Output word comes straight from the FIFO that was last read.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (QW'(i) == out_qid_q) out_data = q_dataout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Turn/credit FSM with registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= QW'(NUM_Q - 1);
      credit_q    <= '0;
      out_valid_q <= 1'b0;
      out_qid_q   <= '0;
    end else if (issue) begin
      state_q     <= SERVE;
      cur_q       <= target;
      out_qid_q   <= target;
      out_valid_q <= 1'b1;
      credit_q    <= cont_turn ? (credit_q - ONE_W) : (tgt_weight - ONE_W);
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      if ((state_q == SERVE) && (!any_elig || !enable)) begin
        state_q  <= IDLE;
        credit_q <= '0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_qid     = out_qid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_wrr_scheduler.sv
// Bench for fifo_wrr_scheduler: behavioural FIFOs feed the DUT, expected
// {qid, word} pairs are queued as stimulus is built and popped on transfer.
module tb_fifo_wrr_scheduler;
  import fifo_sched_pkg::*;

  localparam int NQ = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int QW = qid_width(NQ);
  localparam int EW = QW + DW;
  localparam int D  = 64;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic [NQ*WW-1:0] weights;
  logic [NQ-1:0]   q_empty;
  logic [NQ-1:0]   q_rd_en;
  logic [NQ*DW-1:0] q_dataout;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [QW-1:0]   out_qid;
  sched_state_e    dbg_state;

  logic [DW-1:0] mem [NQ][D];
  int            wr_ptr [NQ];
  int            rd_ptr [NQ];
  int            exp_rd [NQ];

  logic [EW-1:0] exp_q [$];
  int            n_total, n_bad, cyc, first_cyc, last_cyc;
  bit            sb_on;

  fifo_wrr_scheduler #(.NUM_Q(NQ), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .weights     (weights),
    .q_empty     (q_empty),
    .q_rd_en     (q_rd_en),
    .q_dataout   (q_dataout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_qid     (out_qid),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- FIFO models (registered read data) ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) rd_ptr[i] <= wr_ptr[i];
      q_dataout <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (q_rd_en[i] && (rd_ptr[i] != wr_ptr[i])) begin
          q_dataout[i*DW +: DW] <= mem[i][rd_ptr[i] % D];
          rd_ptr[i] <= rd_ptr[i] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NQ; i++) q_empty[i] = (rd_ptr[i] == wr_ptr[i]);
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  // Per-cycle monitor, sampled 1 time unit after the falling edge.
  task automatic sample();
    logic [EW-1:0] e;
    if (q_rd_en != '0) begin
      chk("rd_onehot", 64'($onehot(q_rd_en)), 64'd1);
      chk("rd_nonempty", 64'(q_rd_en & q_empty), 64'd0);
    end
    if (sb_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("word", 64'({out_qid, out_data}), 64'(e));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  endtask

  task automatic tick();
    #1;
    sample();
    @(negedge clk);
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_weights(input int w0, input int w1, input int w2, input int w3);
    weights = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endtask

  task automatic push(input int q, input int n);
    for (int k = 0; k < n; k++) begin
      mem[q][wr_ptr[q] % D] = $urandom;
      wr_ptr[q] = wr_ptr[q] + 1;
    end
  endtask

  task automatic exp_push(input int q);
    exp_q.push_back({QW'(q), mem[q][exp_rd[q] % D]});
    exp_rd[q] = exp_rd[q] + 1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) tick();
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_total = 0; n_bad = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    sb_on = 1'b1;
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1; weights = '0;
    for (int i = 0; i < NQ; i++) begin wr_ptr[i] = 0; exp_rd[i] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rden", 64'(q_rd_en), 64'd0);
    chk("rst_qid", 64'(out_qid), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));

    // weights 2,1,1,1, six words each: q0 q0 q1 q2 q3 x3, then q1 q2 q3 x3
    set_weights(2, 1, 1, 1);
    for (int q = 0; q < NQ; q++) push(q, 6);
    for (int r = 0; r < 3; r++) begin exp_push(0); exp_push(0); exp_push(1); exp_push(2); exp_push(3); end
    for (int r = 0; r < 3; r++) begin exp_push(1); exp_push(2); exp_push(3); end
    first_cyc = -1;
    enable = 1'b1;
    drain("t1_drain", 200);
    chk("t1_span", 64'(last_cyc - first_cyc), 64'd23);
    tick(); tick();
    chk("t1_idle_valid", 64'(out_valid), 64'd0);
    chk("t1_idle_state", 64'(dbg_state), 64'(IDLE));

    // only q2 with three words at weight 1
    enable = 1'b0;
    set_weights(1, 1, 1, 1);
    push(2, 3);
    for (int k = 0; k < 3; k++) exp_push(2);
    first_cyc = -1;
    enable = 1'b1;
    drain("t2_drain", 50);
    chk("t2_span", 64'(last_cyc - first_cyc), 64'd2);
    tick(); tick();
    chk("t2_valid_low", 64'(out_valid), 64'd0);
    chk("t2_state_idle", 64'(dbg_state), 64'(IDLE));

    // q0 weight 4 with 2 words ends its turn early; q1 weight 1 with 5 words
    enable = 1'b0;
    set_weights(4, 1, 0, 0);
    push(0, 2); push(1, 5);
    exp_push(0); exp_push(0);
    for (int k = 0; k < 5; k++) exp_push(1);
    first_cyc = -1;
    enable = 1'b1;
    drain("t3_drain", 50);
    chk("t3_span", 64'(last_cyc - first_cyc), 64'd6);

    // backpressure: out_ready low for three cycles with a word pending
    enable = 1'b0;
    tick();
    set_weights(1, 1, 1, 1);
    push(0, 4); push(1, 4);
    for (int k = 0; k < 4; k++) begin exp_push(0); exp_push(1); end
    out_ready = 1'b0;
    enable = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_word", 64'({out_qid, out_data}), 64'(exp_q[0]));
      chk("stall_rden", 64'(q_rd_en), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    first_cyc = -1;
    #1;
    chk("resume_rden", 64'(q_rd_en != '0), 64'd1);
    drain("t4_drain", 50);
    chk("t4_span", 64'(last_cyc - first_cyc), 64'd7);

    // a nonempty queue with weight 0 is never read
    enable = 1'b0;
    tick();
    set_weights(3, 0, 3, 3);
    push(1, 2);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("w0_rden", 64'(q_rd_en), 64'd0);
      chk("w0_valid", 64'(out_valid), 64'd0);
    end

    // asynchronous reset in the middle of a stream
    set_weights(1, 1, 1, 1);
    push(0, 4); push(2, 4);
    sb_on = 1'b0;
    repeat (4) tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_rden", 64'(q_rd_en), 64'd0);
    chk("arst_qid", 64'(out_qid), 64'd0);
    chk("arst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NQ; i++) exp_rd[i] = wr_ptr[i];
    exp_q.delete();
    rst_n = 1'b1;
    sb_on = 1'b1;
    push(1, 2); push(3, 2);
    exp_push(1); exp_push(3); exp_push(1); exp_push(3);
    first_cyc = -1;
    drain("t6_drain", 50);
    chk("t6_span", 64'(last_cyc - first_cyc), 64'd3);

    enable = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wrr_scheduler.md
# fifo_wrr_scheduler

Weighted round-robin read scheduler that drains NUM_Q instances of the team's synchronous FIFO (registered read data, combinational empty flag) into one valid/ready output stream. It owns the FIFOs' read side: it monitors each queue's empty flag, issues one-hot read strobes, and presents the returned word with its queue ID. It sits between the per-source ingress FIFOs and the single downstream consumer.

## Interface
- NUM_Q, 4, number of queues served; must be 2 or more.
- DATA_WIDTH, 32, FIFO word width.
- WEIGHT_WIDTH, 4, width of each per-queue weight.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  permits new reads; when low, a pending output still completes.
- weights  in  NUM_Q*WEIGHT_WIDTH  weight of queue i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; 0 disables the queue.
- q_empty  in  NUM_Q  empty flag of each FIFO.
- q_rd_en  out  NUM_Q  one-hot-or-zero read strobe to each FIFO, with cs tied high.
- q_dataout  in  NUM_Q*DATA_WIDTH  registered dataout of each FIFO.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_WIDTH  word being presented.
- out_qid  out  $clog2(NUM_Q)  source queue of out_data.

## Operation
- eligible[i] = !q_empty[i] && weights[i] != 0.
- Registered state:
  - cur: queue holding the current turn.
  - credit: remaining reads left in the turn, WEIGHT_WIDTH bits.
  - FSM state: IDLE or SERVE.
  - out_valid, out_qid.
- slot_free = !out_valid || out_ready.
- issue = enable && slot_free && (some eligible bit is set).
- Target selection, each cycle:
  - If state is SERVE, credit != 0 and eligible[cur]: target is cur (turn continues).
  - Otherwise: target is the first eligible queue searching cur+1, cur+2, … wrapping, with cur checked last. This starts a new turn.
- On issue:
  - q_rd_en[target] is 1.
  - out_qid <= target, out_valid <= 1, cur <= target.
  - Continuing turn: credit <= credit-1.
  - New turn: credit <= weights[target]-1. The weight is sampled only at turn start.
- No issue and out_ready: out_valid <= 0.
- Turn end conditions:
  - credit reaches 0.
  - cur becomes ineligible mid-turn. Remaining credit is forfeited; no deficit carried.
- FSM transitions:
  - IDLE->SERVE on issue.
  - SERVE->IDLE when no eligible queue exists or enable is low; credit cleared on entering IDLE.
- out_data = q_dataout slice selected by out_qid (combinational mux). It stays stable while stalled because that FIFO receives no further read until the word is accepted.
- q_rd_en is never asserted for a queue whose q_empty is 1 in the same cycle.

## Timing
- Reset values:
  - q_rd_en 0, out_valid 0, out_qid 0.
  - cur NUM_Q-1, so the first search starts at queue 0.
  - credit 0, state IDLE.
- Latency: q_rd_en in cycle t gives out_valid and matching out_data in cycle t+1.
- Throughput: one word per cycle with out_ready held high.
- Handshake:
  - A word transfers in any cycle with out_valid && out_ready.
  - While out_valid && !out_ready: out_data and out_qid are held and q_rd_en is all zero.
- Simultaneous accept and issue in the same cycle: the new word replaces the old one at the next edge with no bubble.
- Weight changes mid-turn take effect at the next turn start.
- Reset asserted mid-operation: all state returns immediately to reset values. An in-flight word is dropped; the FIFO pointers reset in parallel.
- cur/target arithmetic wraps modulo NUM_Q. NUM_Q need not be a power of two; the wrap is an explicit compare.

## Structure
- Package fifo_sched_pkg holds:
  - the state enum (IDLE, SERVE);
  - a qid_width function ($clog2 wrapper);
  - the default NUM_Q, DATA_WIDTH and WEIGHT_WIDTH constants.
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req vector, base index.
  - Outputs: found, index of first set bit after base (wrapping).
  - Reused by the write-side arbiter.

## Test plan
- All four queues non-empty, weights 2,1,1,1, out_ready=1 -> q_rd_en order q0,q0,q1,q2,q3,q0,q0,…; one out_valid word per cycle, out_qid matching, words in FIFO order.
- Only q2 holds 3 words, weight 1 -> three back-to-back reads from q2, then out_valid falls and state returns to IDLE.
- q0 weight 4 with 2 words, q1 with 5 words at weight 1 -> q0,q0,q1,q0? no (q0 empty),q1,q1,… The turn ends early on empty; the credit is not carried.
- out_ready low for 3 cycles while out_valid=1 -> out_data/out_qid stable, q_rd_en=0 all 3 cycles; reads resume the cycle out_ready returns.
- q1 non-empty with weight 0, others empty -> no q_rd_en ever; out_valid stays 0.
- rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0 and q_rd_en=0 asynchronously; after release, first grant goes to the lowest-index eligible queue.
